// File: rtl/count_seq_checker.sv
// Monitor for a W-bit binary counter: checks q/qbar complement consistency and
// modulo-2^W sequencing. Optional up/down checking is enabled by SEQ_CHK_UPDOWN_EN.
module count_seq_checker #(
  parameter int unsigned W        = 2,
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
`ifdef SEQ_CHK_UPDOWN_EN
  input  logic          dir,
`endif
  input  logic [W-1:0]  q_in,
  input  logic [W-1:0]  qbar_in,
  input  logic          err_clr,
  output logic          locked,
  output logic          err_flag,
  output logic [CW-1:0] err_count,
  output logic          wrap_pulse,
  output logic [W-1:0]  expected
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int unsigned GW = 8;
  localparam logic [GW-1:0] LOCK_LEN_C = GW'(LOCK_LEN);
  localparam logic [GW-1:0] GOOD_ONE   = GW'(1'b1);
  localparam logic [W-1:0]  W_ONE      = W'(1'b1);
  localparam logic [W-1:0]  W_ZERO     = {W{1'b0}};
  localparam logic [W-1:0]  W_ALL1     = {W{1'b1}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  state_e         state_q, state_d;
  logic [GW-1:0]  good_q, good_d;
  logic [W-1:0]   exp_q, exp_d;
  logic           locked_q, locked_d;
  logic           flag_q, flag_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wrap_q, wrap_d;

  logic           dir_s;
  logic           comp_err_s;
  logic           seq_ok_s;
  logic           err_hit_s;
  logic [W-1:0]   next_val_s;
  logic [W-1:0]   wrap_val_s;

`ifdef SEQ_CHK_UPDOWN_EN
  assign dir_s = dir;
`else
  assign dir_s = 1'b0;
`endif

  assign comp_err_s = (q_in != ~qbar_in);
  assign seq_ok_s   = (q_in == exp_q);
  assign next_val_s = dir_s ? (q_in - W_ONE) : (q_in + W_ONE);
  // A correct sample at the counting boundary marks a wrap in either direction.
  assign wrap_val_s = dir_s ? W_ALL1 : W_ZERO;

  // Sequence FSM: next state, expected value, good-run counter, wrap detect.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    exp_d     = exp_q;
    wrap_d    = 1'b0;
    err_hit_s = 1'b0;
    if (en) begin
      if (comp_err_s) begin
        err_hit_s = 1'b1;
        if (state_q == ST_LOCKED) begin
          state_d = ST_SYNC;
          good_d  = {GW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            exp_d   = next_val_s;
            good_d  = {GW{1'b0}};
            state_d = ST_SYNC;
          end
          ST_SYNC: begin
            exp_d = next_val_s;
            if (seq_ok_s) begin
              if ((good_q + GOOD_ONE) == LOCK_LEN_C) begin
                good_d  = {GW{1'b0}};
                state_d = ST_LOCKED;
              end else begin
                good_d  = good_q + GOOD_ONE;
              end
            end else begin
              good_d = {GW{1'b0}};
            end
          end
          ST_LOCKED: begin
            exp_d = next_val_s;
            if (seq_ok_s) begin
              wrap_d = (q_in == wrap_val_s);
            end else begin
              err_hit_s = 1'b1;
              good_d    = {GW{1'b0}};
              state_d   = ST_SYNC;
            end
          end
          default: begin
            state_d = ST_IDLE;
            good_d  = {GW{1'b0}};
            exp_d   = W_ZERO;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  // Error bookkeeping: a new error outranks a coincident clear.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (en) begin
      if (err_hit_s) begin
        flag_d = 1'b1;
        if (err_clr) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (err_clr) begin
        cnt_d  = {CW{1'b0}};
        flag_d = 1'b0;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      good_q   <= {GW{1'b0}};
      exp_q    <= W_ZERO;
      locked_q <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign locked     = locked_q;
  assign err_flag   = flag_q;
  assign err_count  = cnt_q;
  assign wrap_pulse = wrap_q;
  assign expected   = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker (W=2, LOCK_LEN=4, CW=2) with a
// behavioural reference model and directed plus randomized scenarios.
module tb_count_seq_checker;

  localparam int W        = 2;
  localparam int LOCK_LEN = 4;
  localparam int CW       = 2;
  localparam int MOD      = 4;
  localparam int CMAX     = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [W-1:0]  q_in = 2'd0;
  logic [W-1:0]  qbar_in = 2'd3;
  logic          err_clr = 1'b0;
  logic          locked;
  logic          err_flag;
  logic [CW-1:0] err_count;
  logic          wrap_pulse;
  logic [W-1:0]  expected;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 = idle, 1 = hunting for a run, 2 = locked.
  int m_mode = 0;
  int m_exp  = 0;
  int m_good = 0;
  int m_cnt  = 0;
  bit m_flag = 1'b0;
  bit m_wrap = 1'b0;

  count_seq_checker #(.W(W), .LOCK_LEN(LOCK_LEN), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
`ifdef SEQ_CHK_UPDOWN_EN
    .dir        (1'b0),
`endif
    .q_in       (q_in),
    .qbar_in    (qbar_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_flag   (err_flag),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse),
    .expected   (expected)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int  qv;
    int  qbv;
    bit  cerr;
    bit  counted;
    qv      = int'(q_in);
    qbv     = int'(qbar_in);
    m_wrap  = 1'b0;
    counted = 1'b0;
    if (reset) begin
      m_mode = 0; m_exp = 0; m_good = 0; m_cnt = 0; m_flag = 1'b0;
      return;
    end
    if (!en) return;
    cerr = (qv + qbv) != (MOD - 1);
    if (cerr) begin
      counted = 1'b1;
      if (m_mode == 2) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 0) begin
      m_exp = (qv + 1) % MOD; m_good = 0; m_mode = 1;
    end else if (m_mode == 1) begin
      if (qv == m_exp) begin
        m_good = m_good + 1;
        if (m_good == LOCK_LEN) m_mode = 2;
      end else begin
        m_good = 0;
      end
      m_exp = (qv + 1) % MOD;
    end else begin
      if (qv == m_exp) m_wrap = (qv == 0);
      else begin counted = 1'b1; m_mode = 1; m_good = 0; end
      m_exp = (qv + 1) % MOD;
    end
    if (counted) begin
      m_flag = 1'b1;
      m_cnt  = err_clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
    end else if (err_clr) begin
      m_cnt = 0; m_flag = 1'b0;
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [1:0] c;
    logic [1:0] e;
    c = 2'(m_cnt);
    e = 2'(m_exp);
    return {(m_mode == 2), m_flag, c, m_wrap, e};
  endfunction

  task automatic apply(input logic r, input logic e, input logic [1:0] q,
                       input logic [1:0] qb, input logic c);
    @(negedge clk);
    reset = r; en = e; q_in = q; qbar_in = qb; err_clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic valid(input logic [1:0] q);
    apply(1'b0, 1'b1, q, q ^ 2'b11, 1'b0);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 2'd0, 2'd3, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({locked, err_flag, err_count, wrap_pulse, expected} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", {locked, err_flag, err_count, wrap_pulse, expected}, 7'b0);
    end
  endtask

  task automatic test_lockup();
    logic [1:0] seq [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      valid(seq[i]);
      n_vec++;
      if ({locked, err_flag, err_count, wrap_pulse, expected} !== model_vec()) begin
        n_err++;
        $display("FAIL lockup_model step %0d: got %b want %b", i, {locked, err_flag, err_count, wrap_pulse, expected}, model_vec());
      end
      n_vec++;
      if (locked !== (i >= 4)) begin
        n_err++;
        $display("FAIL lockup_locked step %0d: got %b want %b", i, locked, (i >= 4));
      end
      n_vec++;
      if (wrap_pulse !== (i == 8)) begin
        n_err++;
        $display("FAIL lockup_wrap step %0d: got %b want %b", i, wrap_pulse, (i == 8));
      end
    end
    valid(2'd1);
    n_vec++;
    if ({wrap_pulse, err_count, expected} !== {1'b0, 2'd0, 2'd2}) begin
      n_err++;
      $display("FAIL lockup_after_wrap: got %b want %b", {wrap_pulse, err_count, expected}, {1'b0, 2'd0, 2'd2});
    end
  endtask

  task automatic test_seq_error();
    valid(2'd3);
    n_vec++;
    if ({locked, err_flag, err_count, expected} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
      n_err++;
      $display("FAIL seq_error: got %b want %b", {locked, err_flag, err_count, expected}, {1'b0, 1'b1, 2'd1, 2'd0});
    end
    for (int i = 0; i < 4; i++) begin
      valid(2'(i));
      n_vec++;
      if (locked !== (i == 3)) begin
        n_err++;
        $display("FAIL seq_relock step %0d: got %b want %b", i, locked, (i == 3));
      end
    end
  endtask

  task automatic test_comp_err_idle();
    do_reset();
    apply(1'b0, 1'b1, 2'd1, 2'd1, 1'b0);
    n_vec++;
    if ({locked, err_flag, err_count, expected} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
      n_err++;
      $display("FAIL comp_err_idle: got %b want %b", {locked, err_flag, err_count, expected}, {1'b0, 1'b1, 2'd1, 2'd0});
    end
    valid(2'd2);
    n_vec++;
    if (expected !== 2'd3) begin
      n_err++;
      $display("FAIL comp_err_then_seed: got %0d want 3", expected);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    n_vec++;
    if ({err_flag, err_count} !== {1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL saturate: got %b want %b", {err_flag, err_count}, {1'b1, 2'd3});
    end
    apply(1'b0, 1'b1, 2'd0, 2'd3, 1'b1);
    n_vec++;
    if ({err_flag, err_count} !== {1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL clear_alone: got %b want %b", {err_flag, err_count}, {1'b0, 2'd0});
    end
    apply(1'b0, 1'b1, 2'd2, 2'd2, 1'b1);
    n_vec++;
    if ({err_flag, err_count} !== {1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL clear_with_error: got %b want %b", {err_flag, err_count}, {1'b1, 2'd1});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1'b0, 1'b1, 2'd3, 2'd3, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) valid(2'(i % 4));
    n_vec++;
    if ({locked, err_count} !== {1'b1, 2'd2}) begin
      n_err++;
      $display("FAIL reset_mid_setup: got %b want %b", {locked, err_count}, {1'b1, 2'd2});
    end
    apply(1'b1, 1'b1, 2'd1, 2'd2, 1'b0);
    n_vec++;
    if ({locked, err_flag, err_count, wrap_pulse, expected} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_mid: got %b want %b", {locked, err_flag, err_count, wrap_pulse, expected}, 7'b0);
    end
    valid(2'd3);
    n_vec++;
    if ({locked, expected} !== {1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_mid_idle: got %b want %b", {locked, expected}, {1'b0, 2'd0});
    end
  endtask

  task automatic test_en_gating();
    logic [6:0] snap;
    do_reset();
    for (int i = 1; i <= 5; i++) valid(2'(i % 4));
    valid(2'd2);
    valid(2'd3);
    valid(2'd0);
    n_vec++;
    if ({locked, wrap_pulse, expected} !== {1'b1, 1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL en_setup: got %b want %b", {locked, wrap_pulse, expected}, {1'b1, 1'b1, 2'd1});
    end
    snap = {1'b1, 1'b0, 2'd0, 1'b0, 2'd1};
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
      n_vec++;
      if ({locked, err_flag, err_count, wrap_pulse, expected} !== snap) begin
        n_err++;
        $display("FAIL en_hold cycle %0d: got %b want %b", i, {locked, err_flag, err_count, wrap_pulse, expected}, snap);
      end
    end
    valid(2'd1);
    n_vec++;
    if ({locked, err_flag, err_count, expected} !== {1'b1, 1'b0, 2'd0, 2'd2}) begin
      n_err++;
      $display("FAIL en_resume: got %b want %b", {locked, err_flag, err_count, expected}, {1'b1, 1'b0, 2'd0, 2'd2});
    end
  endtask

  task automatic test_random();
    logic       r, e, c;
    logic [1:0] q, qb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 85);
      q  = ($urandom_range(0, 99) < 75) ? 2'(m_exp) : 2'($urandom_range(0, 3));
      qb = ($urandom_range(0, 99) < 90) ? (q ^ 2'b11) : 2'($urandom_range(0, 3));
      c  = e && ($urandom_range(0, 99) < 6);
      apply(r, e, q, qb, c);
      n_vec++;
      if ({locked, err_flag, err_count, wrap_pulse, expected} !== model_vec()) begin
        n_err++;
        $display("FAIL random cycle %0d: got %b want %b", i, {locked, err_flag, err_count, wrap_pulse, expected}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_seq_error();
    test_comp_err_idle();
    test_saturation_clear();
    test_reset_mid();
    test_en_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Synchronous monitor downstream of the JK-flop binary counter stage.
- Consumes the counter's true and complement outputs (q, qbar) and checks complement consistency and modulo-2^W increment sequencing.
- Reports lock status, a sticky error flag, a saturating error count and a wrap pulse.
- Used for in-system self-check of counter chains and as a bench-reusable checker.

Parameters:
- W, 2, counter width under check (1..16).
- LOCK_LEN, 4, consecutive correct increments after the seed sample required to enter LOCKED (1..255).
- CW, 8, error counter width (>=1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk edge.
- en  input  1  sample qualifier; q_in/qbar_in are evaluated only on edges where en=1.
- q_in  input  W  counter true outputs.
- qbar_in  input  W  counter complement outputs.
- err_clr  input  1  synchronous clear of err_flag and err_count.
- locked  output  1  high while the FSM is in LOCKED.
- err_flag  output  1  sticky, set on any counted error.
- err_count  output  CW  saturating count of errors.
- wrap_pulse  output  1  one-cycle pulse on a correct wrap sample while LOCKED.
- expected  output  W  next value the checker expects.

Behaviour:
- All outputs are registered and change only on the rising edge of clk. Latency from the sampled edge to the output update is 1 edge.
- Reset (synchronous, active-high): state=IDLE, locked=0, err_flag=0, err_count=0, wrap_pulse=0, expected=0, internal good-counter=0. Reset has priority over every other input, including mid-LOCKED.
- en=0: all state and outputs hold, except wrap_pulse, which is forced to 0.
- comp_err = (q_in != ~qbar_in). seq_ok = (q_in == expected). Increment is modulo 2^W: 2^W-1 -> 0.
- comp_err on a sampled edge, in any state:
  - Error is counted.
  - State and expected are left unchanged, except that LOCKED drops to SYNC with good-counter=0.
- Error counting:
  - err_count increments by 1 and saturates at 2^CW-1.
  - err_flag is set to 1.
- IDLE: on a valid sample (no comp_err), expected <= q_in+1, good-counter=0, go to SYNC. No sequence error is possible in IDLE.
- SYNC:
  - Valid sample with seq_ok: good-counter++, expected <= q_in+1. When good-counter reaches LOCKED_LEN, go to LOCKED; locked=1 after that edge.
  - Valid sample with !seq_ok: reseed expected <= q_in+1, good-counter=0, stay in SYNC. Not counted as an error.
- LOCKED:
  - Valid sample with seq_ok: expected <= q_in+1. If q_in==0, wrap_pulse=1 for that cycle.
  - Valid sample with !seq_ok: error counted, expected <= q_in+1, good-counter=0, go to SYNC; locked=0 after that edge.
- err_clr:
  - err_clr=1 with no simultaneous counted error: err_count=0, err_flag=0.
  - err_clr=1 coincident with a counted error: the new error wins; err_count=1, err_flag=1.
  - err_clr does not affect the FSM.
- wrap_pulse is never high for 2 consecutive cycles unless en=1 and W=1.

Optional Feature:
- Macro: SEQ_CHK_UPDOWN_EN.
- Defined: adds input port dir (1 bit), placed after en.
  - dir=0 expects q+1; dir=1 expects q-1, modulo 2^W.
  - In LOCKED with dir=1, wrap_pulse fires on a correct sample of 2^W-1.
  - A dir change while LOCKED is legal; the next expected value uses the dir sampled on that edge.
- Undefined: no dir port, increment-only behaviour as above.

Test Plan:
- Lock-up: W=2, LOCK_LEN=4, reset then en=1 with q_in=0,1,2,3,0 and qbar=~q -> locked=1 after the 5th edge. Continue with 1,2,3,0 -> wrap_pulse=1 for exactly 1 cycle after the sample of 0; err_count=0.
- Sequence error: while LOCKED and expected=2, drive q_in=3 -> next edge: err_flag=1, err_count=1, locked=0, expected=0. Then 0,1,2,3 -> locked=1 again.
- Complement error in IDLE: after reset, drive q_in=1, qbar_in=1 -> err_count=1, err_flag=1, state remains IDLE, expected=0. Then a valid q_in=2 -> expected=3.
- Saturation and clear: CW=2, inject 5 errors -> err_count holds 3. Drive err_clr=1 alone -> 0. Drive err_clr=1 together with an error -> err_count=1, err_flag=1.
- Reset mid-operation: assert reset for 1 cycle while LOCKED with err_count=2 -> next edge all outputs 0 and state=IDLE.
- en gating: while LOCKED, hold en=0 for 10 cycles with garbage on q_in -> no output changes, wrap_pulse=0. With en=1 resuming at the expected value -> still locked, no error.
